// File: rtl/regfile.sv
// regfile: 32x32 register file, r0 hardwired to zero; sync write port (we/waddr/wdata), two combinational read ports (re/raddr -> rdata) with write-through bypass
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we && waddr != '0) regs[waddr] <= wdata;
  always_comb begin
    rdata1 = (rst || !re1 || raddr1 == '0) ? '0 : (we && raddr1 == waddr) ? wdata : regs[raddr1];
    rdata2 = (rst || !re2 || raddr2 == '0) ? '0 : (we && raddr2 == waddr) ? wdata : regs[raddr2];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile
module tb_regfile;
  logic clk = 0, rst, we, re1, re2;
  logic [4:0] waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic [63:0] sb [$];
  int vectors = 0, miscompares = 0;

  regfile dut (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
               .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
               .re2(re2), .raddr2(raddr2), .rdata2(rdata2));

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                      input logic e2, input logic [4:0] a2, input logic [31:0] x1, input logic [31:0] x2);
    logic [63:0] e;
    rst = r; we = w; waddr = wa; wdata = wd; re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    sb.push_back({x1, x2});
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    assert (rdata1 === e[63:32]) else begin
      miscompares++;
      $error("FAIL %s rdata1 observed=%h expected=%h", tag, rdata1, e[63:32]);
    end
    vectors++;
    assert (rdata2 === e[31:0]) else begin
      miscompares++;
      $error("FAIL %s rdata2 observed=%h expected=%h", tag, rdata2, e[31:0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    @(posedge clk); #1;
    step("reset_idle",     1, 0, 0, 0,            1, 5, 1, 3, 0, 0);
    step("bypass_r5",      0, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 32'hDEADBEEF, 0);
    step("stored_r5",      0, 0, 0, 0,            1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    step("rst_masks",      1, 1, 5, 32'h1,        1, 5, 1, 5, 0, 0);
    step("r5_cleared",     0, 0, 0, 0,            1, 5, 1, 5, 0, 0);
    step("re_off_bypass",  0, 1, 3, 32'h12345678, 0, 3, 0, 3, 0, 0);
    step("read_r3",        0, 0, 0, 0,            1, 3, 0, 3, 32'h12345678, 0);
    step("write_r7",       0, 1, 7, 32'h1,        0, 0, 1, 7, 0, 32'h1);
    step("bypass_r7",      0, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step("stored_r7",      0, 0, 0, 0,            1, 7, 1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step("r0_write",       0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0);
    step("r0_after",       0, 0, 0, 0,            1, 0, 1, 3, 0, 32'h12345678);
    step("write_in_rst",   1, 1, 9, 32'h0000BEEF, 1, 9, 1, 9, 0, 0);
    step("r9_after_rst",   0, 0, 0, 0,            1, 9, 1, 7, 0, 0);
    for (int i = 1; i < 32; i++)
      step("sweep_wr", 0, 1, 5'(i), i * 32'h01010101, 1, 5'(i), 1, 0, i * 32'h01010101, 0);
    for (int i = 0; i < 32; i++)
      step("sweep_rd", 0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i), i * 32'h01010101, (31 - i) * 32'h01010101);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
endmodule
